// File: rtl/arith_decode_target.sv
// Decoder-side target scaling: target = ((code - low + 1) * total - 1) / range,
// computed with an exact radix-2 restoring divider so targets match the encoder bit for bit.
module arith_decode_target #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] code_in,
  input  logic [WIDTH-1:0] low_in,
  input  logic [WIDTH-1:0] range_in,
  input  logic [WIDTH-1:0] total_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] target_out,
  output logic             err_out
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   diff_q, range_q, total_q, quot_q, rem_q;
  logic [2*WIDTH-1:0] num_q;
  logic [CW-1:0]      cnt_q;
  logic               err_q, load_q;

  logic [WIDTH-1:0]   diff_d;
  logic [WIDTH:0]     diff_p1;
  logic [2*WIDTH-1:0] num_d;
  logic [WIDTH:0]     rem_sh;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_d, quot_d;

  always_comb begin
    diff_d  = code_in - low_in;
    diff_p1 = {1'b0, diff_q} + (WIDTH+1)'(1);
    // Truncation to 2W bits is exact for legal requests; illegal ones are overridden in DONE.
    num_d   = (2*WIDTH)'(diff_p1) * (2*WIDTH)'(total_q) - (2*WIDTH)'(1);
    rem_sh  = {rem_q, num_q[2*WIDTH-1]};
    q_bit   = (rem_sh >= {1'b0, range_q});
    rem_d   = q_bit ? WIDTH'(rem_sh - {1'b0, range_q}) : rem_sh[WIDTH-1:0];
    quot_d  = {quot_q[WIDTH-2:0], q_bit};
  end

  assign in_ready = (state_q == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      diff_q     <= '0;
      range_q    <= '0;
      total_q    <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      num_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      load_q     <= 1'b0;
      out_valid  <= 1'b0;
      target_out <= '0;
      err_out    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          diff_q  <= diff_d;
          range_q <= range_in;
          total_q <= total_in;
          err_q   <= (range_in == '0) || (total_in == '0) || (diff_d >= range_in);
          state_q <= MUL;
        end
        MUL: begin
          num_q   <= num_d;
          load_q  <= 1'b1;
          state_q <= DIV;
        end
        DIV: begin
          // First DIV cycle seeds the remainder with the numerator's upper half.
          if (load_q) begin
            rem_q  <= num_q[2*WIDTH-1:WIDTH];
            num_q  <= {num_q[WIDTH-1:0], {WIDTH{1'b0}}};
            cnt_q  <= '0;
            load_q <= 1'b0;
          end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            num_q  <= {num_q[2*WIDTH-2:0], 1'b0};
            cnt_q  <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              state_q    <= DONE;
              out_valid  <= 1'b1;
              target_out <= err_q ? '1 : quot_d;
              err_out    <= err_q;
            end
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
